// File: rtl/mp_add_seq_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// datapath word width, FSM state encoding and the signed-overflow rule.
package mp_add_seq_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Two's-complement overflow: operands agree in sign, result sign differs.
    function automatic logic signed_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/full_adder_16bit.sv
// 16-bit ripple-carry adder used as the shared word datapath of mp_add_seq.
module full_adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] carry_s;

    assign carry_s[0] = cin;

    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign sum[i]         = a[i] ^ b[i] ^ carry_s[i];
        assign carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end

    assign cout = carry_s[16];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: walks WORDS 16-bit words through one
// shared adder, LS word first, and returns sum/carry/overflow via valid/ready.
module mp_add_seq
    import mp_add_seq_pkg::*;
#(
    parameter int WORDS = 4,
    parameter int IDXW  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic                    sub,
    input  logic                    cin,
    input  logic [WORD_W*WORDS-1:0] a,
    input  logic [WORD_W*WORDS-1:0] b,
    output logic                    done_valid,
    input  logic                    done_ready,
    output logic [WORD_W*WORDS-1:0] sum,
    output logic                    cout,
    output logic                    ovf
);

    localparam int              W        = WORD_W * WORDS;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    if ((WORDS < 2) || ((2 ** IDXW) < WORDS)) begin : g_param_check
        $error("mp_add_seq: need WORDS >= 2 and 2**IDXW >= WORDS");
    end

    state_e              state_r;
    state_e              state_next_s;
    logic [W-1:0]        a_r;
    logic [W-1:0]        beff_r;
    logic [W-1:0]        sum_r;
    logic                carry_r;
    logic                cout_r;
    logic                ovf_r;
    logic                done_valid_r;
    logic                start_ready_r;
    logic [IDXW-1:0]     idx_r;
    logic [WORD_W-1:0]   a_word_s;
    logic [WORD_W-1:0]   b_word_s;
    logic [WORD_W-1:0]   add_sum_s;
    logic                add_cout_s;
    logic                last_s;

    // Word select for the shared adder and last-word detect.
    always_comb begin
        a_word_s = a_r[int'(idx_r) * WORD_W +: WORD_W];
        b_word_s = beff_r[int'(idx_r) * WORD_W +: WORD_W];
        last_s   = (idx_r == LAST_IDX);
    end

    full_adder_16bit u_adder (
        .a    (a_word_s),
        .b    (b_word_s),
        .cin  (carry_r),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_valid) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register with registered handshake flags derived from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            start_ready_r <= 1'b1;
            done_valid_r  <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            start_ready_r <= (state_next_s == IDLE);
            done_valid_r  <= (state_next_s == DONE);
        end
    end

    // Operand capture, per-word accumulation and final carry/overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= {W{1'b0}};
            beff_r  <= {W{1'b0}};
            sum_r   <= {W{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            idx_r   <= {IDXW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_valid) begin
                        a_r     <= a;
                        beff_r  <= sub ? ~b : b;
                        carry_r <= sub ? 1'b1 : cin;
                        sum_r   <= {W{1'b0}};
                        idx_r   <= {IDXW{1'b0}};
                    end
                end
                RUN: begin
                    sum_r[int'(idx_r) * WORD_W +: WORD_W] <= add_sum_s;
                    carry_r <= add_cout_s;
                    if (last_s) begin
                        // Top carry leaves through cout only; the index parks at 0.
                        cout_r <= add_cout_s;
                        ovf_r  <= signed_ovf(a_r[W-1], beff_r[W-1], add_sum_s[WORD_W-1]);
                        idx_r  <= {IDXW{1'b0}};
                    end else begin
                        idx_r  <= idx_r + {{(IDXW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    cout_r <= cout_r;
                end
                default: begin
                    idx_r <= {IDXW{1'b0}};
                end
            endcase
        end
    end

    assign start_ready = start_ready_r;
    assign done_valid  = done_valid_r;
    assign sum         = sum_r;
    assign cout        = cout_r;
    assign ovf         = ovf_r;

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq (WORDS=4): wide-arithmetic reference model,
// per-cycle compare process and directed vectors with literal expectations.
module tb_mp_add_seq;

    localparam int WORDS = 4;
    localparam int W     = 64;

    logic         clk         = 1'b0;
    logic         rst         = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic         sub         = 1'b0;
    logic         cin         = 1'b0;
    logic [W-1:0] a           = '0;
    logic [W-1:0] b           = '0;
    logic         done_valid;
    logic         done_ready  = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    mp_add_seq #(.WORDS(WORDS), .IDXW(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .sub         (sub),
        .cin         (cin),
        .a           (a),
        .b           (b),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .sum         (sum),
        .cout        (cout),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference result from plain wide arithmetic: {ovf, cout, sum}.
    function automatic logic [W+1:0] model_op(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                              input logic fsub, input logic fcin);
        logic [W-1:0] beff;
        logic [W:0]   r;
        logic         v;
        beff = fsub ? ~fb : fb;
        r    = {1'b0, fa} + {1'b0, beff} + {{W{1'b0}}, (fsub ? 1'b1 : fcin)};
        v    = (fa[W-1] == beff[W-1]) && (r[W-1] != fa[W-1]);
        return {v, r};
    endfunction

    // Transaction-level model: busy for WORDS edges, then result held until accepted.
    logic         m_busy, m_valid, m_clean, m_cout, m_ovf, p_cout, p_ovf;
    logic [W-1:0] m_sum, p_sum;
    int           m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_clean <= 1'b1;
            m_cnt   <= 0;
            m_sum   <= '0;
            m_cout  <= 1'b0;
            m_ovf   <= 1'b0;
        end else if (m_valid) begin
            if (done_ready) m_valid <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == WORDS - 1) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
                m_sum   <= p_sum;
                m_cout  <= p_cout;
                m_ovf   <= p_ovf;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (start_valid) begin
            {p_ovf, p_cout, p_sum} <= model_op(a, b, sub, cin);
            m_busy  <= 1'b1;
            m_cnt   <= 0;
            m_clean <= 1'b0;
        end
    end

    // Per-cycle compare against the model on the inactive edge.
    always @(negedge clk) begin
        chk("start_ready", {63'd0, start_ready}, {63'd0, !(m_busy || m_valid)});
        chk("done_valid", {63'd0, done_valid}, {63'd0, m_valid});
        if (m_valid || m_clean) begin
            chk("sum", sum, m_sum);
            chk("cout", {63'd0, cout}, {63'd0, m_cout});
            chk("ovf", {63'd0, ovf}, {63'd0, m_ovf});
        end
    end

    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tsub, input logic tcin, input logic [W-1:0] esum,
                          input logic ecout, input logic eovf, input int hold);
        int lat;
        @(posedge clk); #1;
        chk({name, "_ready_before"}, {63'd0, start_ready}, 64'd1);
        a = ta; b = tb; sub = tsub; cin = tcin;
        start_valid = 1'b1;
        done_ready  = (hold == 0);
        @(posedge clk); #1;
        start_valid = 1'b0;
        lat = 0;
        while (!done_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'd4);
        chk({name, "_sum"}, sum, esum);
        chk({name, "_cout"}, {63'd0, cout}, {63'd0, ecout});
        chk({name, "_ovf"}, {63'd0, ovf}, {63'd0, eovf});
        chk({name, "_model_sum"}, m_sum, esum);
        chk({name, "_model_flags"}, {62'd0, m_cout, m_ovf}, {62'd0, ecout, eovf});
        for (int i = 0; i < hold; i++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            sub = ~sub; cin = ~cin;
            start_valid = 1'b1;
            @(posedge clk); #1;
            chk({name, "_hold_sum"}, sum, esum);
            chk({name, "_hold_flags"}, {62'd0, cout, ovf}, {62'd0, ecout, eovf});
            chk({name, "_hold_valid"}, {63'd0, done_valid}, 64'd1);
            chk({name, "_hold_ready"}, {63'd0, start_ready}, 64'd0);
        end
        start_valid = 1'b0;
        done_ready  = 1'b1;
        @(posedge clk); #1;
        chk({name, "_valid_drop"}, {63'd0, done_valid}, 64'd0);
        chk({name, "_ready_back"}, {63'd0, start_ready}, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start_ready", {63'd0, start_ready}, 64'd1);
        chk("rst_done_valid", {63'd0, done_valid}, 64'd0);
        chk("rst_sum", sum, 64'd0);
        rst = 1'b0;

        run_op("ripple", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
               64'h0000_0000_0001_0000, 1'b0, 1'b0, 0);
        run_op("fullcarry", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
               64'h0, 1'b1, 1'b0, 0);
        run_op("borrow", 64'h5, 64'h7, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0);
        run_op("cinign", 64'h7, 64'h5, 1'b1, 1'b1,
               64'h2, 1'b1, 1'b0, 0);
        run_op("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, 0);
        run_op("addcin", 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_000F, 1'b0, 1'b1,
               64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 0);
        run_op("backpr", 64'h7, 64'h5, 1'b1, 1'b1,
               64'h2, 1'b1, 1'b0, 5);

        // Reset in the second RUN cycle of a carry-heavy operation.
        @(posedge clk); #1;
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; sub = 1'b0; cin = 1'b0;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_done_valid", {63'd0, done_valid}, 64'd0);
        chk("midrst_sum", sum, 64'd0);
        chk("midrst_cout", {63'd0, cout}, 64'd0);
        chk("midrst_ovf", {63'd0, ovf}, 64'd0);
        chk("midrst_start_ready", {63'd0, start_ready}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("postrst", 64'h1, 64'h1, 1'b0, 1'b0, 64'h2, 1'b0, 1'b0, 0);
        run_op("negovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0);

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer built around one shared 16-bit adder datapath (`full_adder_16bit`).
- Accepts WORDS×16-bit operands through a valid/ready handshake.
- Feeds the operands to the adder one 16-bit word per cycle, least-significant word first, carrying the adder's carry-out into the next word.
- Returns the wide result, carry and signed overflow through a second valid/ready handshake.

Parameters:
- WORDS, 4, number of 16-bit words per operand (≥2); operand width = 16*WORDS.
- IDXW, 2, width of the word index counter; must satisfy 2**IDXW ≥ WORDS.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  request carries valid operands.
- start_ready  output  1  block can accept a request (high only in IDLE).
- sub  input  1  0 = A+B+cin, 1 = A−B (B inverted, carry-in forced 1, cin ignored).
- cin  input  1  carry-in for add mode.
- a  input  16*WORDS  operand A.
- b  input  16*WORDS  operand B.
- done_valid  output  1  result registers hold a completed result.
- done_ready  input  1  consumer accepts the result.
- sum  output  16*WORDS  result.
- cout  output  1  final carry-out (in sub mode: 1 = no borrow).
- ovf  output  1  two's-complement signed overflow of the full-width operation.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-high on rst. While rst is high, or on its assertion at any point including mid-RUN or in DONE:
  - state goes to IDLE;
  - sum=0, cout=0, ovf=0, done_valid=0, word index=0, carry register=0;
  - start_ready=1 once reset is released.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On an edge with start_valid=1: latch a, b, and the effective B (b inverted when sub=1).
  - Carry register ← (sub ? 1 : cin); index ← 0; clear sum; go to RUN.
  - start_valid=0: stay in IDLE.
- RUN:
  - start_ready=0.
  - Adder inputs: latched A word[idx], effective B word[idx], carry register.
  - Each edge: sum word[idx] ← adder sum; carry register ← adder cout; idx ← idx+1.
  - On the edge processing idx=WORDS−1:
    - cout ← adder cout;
    - ovf ← (A[msb] == Beff[msb]) && (adder sum[15] != A[msb]);
    - go to DONE.
- DONE:
  - done_valid=1; sum, cout and ovf are stable and do not change until the handshake completes.
  - On an edge with done_ready=1: done_valid ← 0; go to IDLE.
  - done_ready=0: hold indefinitely (backpressure).
- Latency: acceptance edge T → done_valid high after edge T+WORDS.
  - Minimum issue interval is WORDS+2 cycles: WORDS RUN cycles, one DONE cycle with immediate accept, one IDLE cycle.
  - A new request cannot be accepted in the same cycle as a result handshake.
- Operand isolation: inputs a, b, sub and cin are sampled only at acceptance; changes during RUN/DONE have no effect.
- Stray inputs:
  - done_ready high outside DONE is ignored.
  - start_valid outside IDLE is ignored; the request is not lost because start_ready=0, and the requester must hold it.
- Wrap-around:
  - The carry from the top word exits only through cout; it is never fed back.
  - The index counter never exceeds WORDS−1 in RUN.
- Intermediate sum words may be observed on sum during RUN. Consumers use sum only when done_valid=1.

Decomposition:
- Shared header file holds:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2 (2'd3 is illegal and recovers to IDLE);
  - WORD_W=16.
- One sub-module: the existing `full_adder_16bit`, instantiated once as the shared datapath. The word select mux, operand/result registers and FSM live in mp_add_seq.

Test Plan (WORDS=4):
- Intra-word carry ripple: add, A=0x0000_0000_0000_FFFF, B=0x1, cin=0 → sum=0x0000_0000_0001_0000, cout=0, ovf=0; done_valid rises exactly 4 edges after acceptance.
- Full-width carry: add, A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, cin=0 → sum=0, cout=1, ovf=0.
- Subtract with borrow: sub, A=0x5, B=0x7 → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
- Subtract with cin ignored: sub=1, A=0x7, B=0x5, cin=1 → sum=0x2, cout=1, ovf=0.
- Signed overflow: add, A=0x7FFF_FFFF_FFFF_FFFF, B=0x1 → sum=0x8000_0000_0000_0000, cout=0, ovf=1.
- Backpressure and isolation: hold done_ready=0 for 5 cycles after done_valid; toggle a/b and start_valid meanwhile → sum/cout/ovf constant, start_ready=0. Raise done_ready → done_valid=0 next cycle, start_ready=1.
- Reset mid-operation: assert rst at the 2nd RUN cycle → done_valid=0, sum=0, cout=0, ovf=0 immediately (asynchronous). After release, a new request completes correctly with no stale carry.
